// File: rtl/mutex_requester_4_pkg.sv
// Shared definitions for the 4-way mutex requester: channel state encoding,
// channel count and a popcount helper for the mutual-exclusion monitor.
package mutex_requester_4_pkg;

    localparam int N_CH = 4;

    typedef enum logic [1:0] {
        CH_IDLE = 2'd0,
        CH_WAIT = 2'd1,
        CH_HOLD = 2'd2,
        CH_REL  = 2'd3
    } ch_state_t;

    function automatic int unsigned popcount(input logic [N_CH-1:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < N_CH; i++) begin
            n += int'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/mutex_requester_4_if.sv
// User-logic and arbiter-facing signal bundle of the mutex requester.
// The slave modport is the requester itself; master is whoever drives it.
interface mutex_requester_4_if
    import mutex_requester_4_pkg::*;
#(
    parameter int HOLD_W = 8
);
    logic [N_CH-1:0]   START;
    logic [HOLD_W-1:0] HOLD_CYC;
    logic [N_CH-1:0]   GNT;
    logic              ERR_CLR;
    logic [N_CH-1:0]   REQ;
    logic [N_CH-1:0]   BUSY;
    logic [N_CH-1:0]   OWN;
    logic [N_CH-1:0]   DONE;
    logic              ERR_MUTEX;
    logic [N_CH-1:0]   ERR_TMO;

    modport master (
        output START, HOLD_CYC, GNT, ERR_CLR,
        input  REQ, BUSY, OWN, DONE, ERR_MUTEX, ERR_TMO
    );

    modport slave (
        input  START, HOLD_CYC, GNT, ERR_CLR,
        output REQ, BUSY, OWN, DONE, ERR_MUTEX, ERR_TMO
    );
endinterface

// File: rtl/mutex_requester_4_ch.sv
// One requester channel: 4-phase REQ/GNT client FSM with a critical-section
// hold counter and a grant-wait timeout counter.
module mutex_req_ch
    import mutex_requester_4_pkg::*;
#(
    parameter int HOLD_W = 8,
    parameter int TMO_W  = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [HOLD_W-1:0] hold_cyc,
    input  logic              gs,
    output logic              req,
    output logic              busy,
    output logic              own,
    output logic              done,
    output logic              tmo_hit
);

    ch_state_t         state, state_nx;
    logic [HOLD_W-1:0] hold_cnt, hold_cnt_nx;
    logic [TMO_W-1:0]  tmo_cnt, tmo_cnt_nx, tmo_cnt_inc;
    logic              done_nx;

    assign tmo_cnt_inc = tmo_cnt + 1'b1;

    always_comb begin
        state_nx    = state;
        hold_cnt_nx = hold_cnt;
        tmo_cnt_nx  = '0;
        done_nx     = 1'b0;
        tmo_hit     = 1'b0;
        unique case (state)
            // A start landing on the DONE cycle is dropped, not queued
            CH_IDLE: if (start && !done) state_nx = CH_WAIT;
            CH_WAIT: begin
                if (gs) begin
                    state_nx    = CH_HOLD;
                    hold_cnt_nx = hold_cyc;
                end else if (tmo_cnt_inc == '1) begin
                    state_nx = CH_REL;
                    tmo_hit  = 1'b1;
                end else begin
                    tmo_cnt_nx = tmo_cnt_inc;
                end
            end
            CH_HOLD: begin
                if (hold_cnt != '0) hold_cnt_nx = hold_cnt - 1'b1;
                else                state_nx    = CH_REL;
            end
            CH_REL: begin
                if (!gs) begin
                    state_nx = CH_IDLE;
                    done_nx  = 1'b1;
                end
            end
            default: state_nx = CH_IDLE;
        endcase
    end

    // REQ is a dedicated flop so the arbiter never sees decode glitches
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= CH_IDLE;
            hold_cnt <= '0;
            tmo_cnt  <= '0;
            done     <= 1'b0;
            req      <= 1'b0;
        end else begin
            state    <= state_nx;
            hold_cnt <= hold_cnt_nx;
            tmo_cnt  <= tmo_cnt_nx;
            done     <= done_nx;
            req      <= (state_nx == CH_WAIT) || (state_nx == CH_HOLD);
        end
    end

    assign busy = (state != CH_IDLE);
    assign own  = (state == CH_HOLD);

endmodule

// File: rtl/mutex_requester_4.sv
// Four-channel mutex requester: grant synchroniser, per-channel client FSMs,
// mutual-exclusion monitor and sticky error flags.
module mutex_requester_4
    import mutex_requester_4_pkg::*;
#(
    parameter int HOLD_W = 8,
    parameter int TMO_W  = 12
) (
    input  logic                CLK,
    input  logic                RST_N,
    mutex_requester_4_if.slave  bus
);

    logic [N_CH-1:0] gnt_p0, gnt_p1;
    logic [N_CH-1:0] req, busy, own, done, tmo_hit;
    logic [N_CH-1:0] err_tmo;
    logic            err_mutex, mutex_hit;

    // Stage p0/p1: two-flop synchroniser on the asynchronous grants
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            gnt_p0 <= '0;
            gnt_p1 <= '0;
        end else begin
            gnt_p0 <= bus.GNT;
            gnt_p1 <= gnt_p0;
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        mutex_req_ch #(
            .HOLD_W (HOLD_W),
            .TMO_W  (TMO_W)
        ) u_ch (
            .clk      (CLK),
            .rst_n    (RST_N),
            .start    (bus.START[i]),
            .hold_cyc (bus.HOLD_CYC),
            .gs       (gnt_p1[i]),
            .req      (req[i]),
            .busy     (busy[i]),
            .own      (own[i]),
            .done     (done[i]),
            .tmo_hit  (tmo_hit[i])
        );
    end

    assign mutex_hit = (popcount(gnt_p1) > 1);

    // Set has priority over a coincident clear
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            err_mutex <= 1'b0;
            err_tmo   <= '0;
        end else begin
            err_mutex <= mutex_hit | (err_mutex & ~bus.ERR_CLR);
            err_tmo   <= tmo_hit | (err_tmo & {N_CH{~bus.ERR_CLR}});
        end
    end

    assign bus.REQ       = req;
    assign bus.BUSY      = busy;
    assign bus.OWN       = own;
    assign bus.DONE      = done;
    assign bus.ERR_MUTEX = err_mutex;
    assign bus.ERR_TMO   = err_tmo;

endmodule

// File: doc/mutex_requester_4.md
Name: mutex_requester_4

Overview:
Requester-side controller for the 4-way mutex arbiter: one client FSM per channel runs a 4-phase request/grant/release handshake against the arbiter's asynchronous grant outputs. Each channel holds the grant for a programmable critical section, then releases it and waits for the grant to fall. A monitor on the synchronised grants flags mutual-exclusion violations and channels that never receive a grant. The block sits between user-logic start pulses and the arbiter's REQ/GNT pins.

Parameters:
N_CH, 4, number of channels; fixed at 4 to match the arbiter.
HOLD_W, 8, width of the critical-section length input.
TMO_W, 12, width of the grant-wait timeout counter; timeout fires at 2^TMO_W-1 cycles.

Ports:
CLK  input  1  single clock for the whole block
RST_N  input  1  asynchronous, active-low reset
START  input  4  per-channel one-cycle start pulse; ignored unless that channel is IDLE
HOLD_CYC  input  HOLD_W  critical-section length in cycles; sampled per channel on grant
GNT  input  4  arbiter grant outputs; asynchronous to CLK
ERR_CLR  input  1  synchronous clear of all sticky error flags
REQ  output  4  requests to the arbiter; registered
BUSY  output  4  channel not IDLE
OWN  output  4  channel is in HOLD, i.e. inside its critical section
DONE  output  4  one-cycle pulse when a channel returns to IDLE after a release
ERR_MUTEX  output  1  sticky flag: more than one synchronised grant seen in a cycle
ERR_TMO  output  4  sticky per-channel flag: grant-wait timeout

Behaviour:
- Reset: all FSMs go to IDLE. REQ, BUSY, OWN, DONE, ERR_MUTEX, ERR_TMO are all 0. Synchroniser flops and counters are cleared.
- GNT passes through a 2-flop synchroniser per bit (gs). All FSM decisions use gs only.
- Per-channel FSM states:
  - IDLE: START[i]=1 -> WAIT. REQ[i] rises on the next edge.
  - WAIT: REQ=1; timeout counter increments each cycle.
    - gs[i]=1 -> HOLD. Load hold counter with HOLD_CYC and clear the timeout counter.
    - Timeout counter reaches all-ones with gs[i]=0 -> set ERR_TMO[i], go to REL.
    - Grant wins over timeout if both occur in the same cycle.
  - HOLD: REQ=1, OWN=1.
    - Counter nonzero -> decrement.
    - Counter zero -> go to REL. HOLD_CYC=0 therefore gives exactly 1 HOLD cycle; HOLD_CYC=N gives N+1.
  - REL: REQ=0. Stay until gs[i]=0, then go to IDLE and pulse DONE[i] for one cycle.
- Latency:
  - START to REQ: 1 cycle.
  - GNT edge to gs: 2 cycles.
  - gs rise to OWN: 1 cycle.
  - REQ fall to DONE: at least 3 cycles, because the grant drop must propagate through the synchroniser.
- Grant dropping while the channel is in HOLD is not an error. The channel finishes its hold count, then waits in REL as normal.
- START while BUSY: ignored, no queuing. START and DONE on the same channel in the same cycle: START is ignored.
- Channels are fully independent. Simultaneous STARTs on several channels are legal, and the arbiter serialises them.
- ERR_MUTEX: set when popcount(gs) > 1. Sticky until ERR_CLR=1. If a set condition and ERR_CLR occur in the same cycle, set wins.
- ERR_TMO[i]: sticky until ERR_CLR=1. If a set condition and ERR_CLR occur in the same cycle, set wins.
- Reset asserted mid-operation: REQ drops asynchronously and all state returns to IDLE. The arbiter releases its grant combinationally.

Decomposition:
- Shared package:
  - channel state encoding: IDLE=2'd0, WAIT=2'd1, HOLD=2'd2, REL=2'd3
  - N_CH
  - popcount helper function
- Sub-module mutex_req_ch: one-channel FSM with its hold and timeout counters, instantiated 4 times.
- Top level owns the synchroniser, the mutex monitor and the error flags.

Test Plan:
- Single channel: START[2] pulse, HOLD_CYC=5, GNT follows REQ with 1-cycle delay -> REQ[2] high at +1, OWN[2] high for 6 cycles, DONE[2] pulse once, other outputs 0.
- Simultaneous START=4'b1111, HOLD_CYC=3, behavioural arbiter model -> OWN one-hot in every cycle, 4 DONE pulses total, ERR_MUTEX=0.
- Force GNT=4'b0011 for 3 cycles -> ERR_MUTEX=1 and stays 1. ERR_CLR pulse -> 0.
- START[0] with GNT tied 0, TMO_W=4 -> ERR_TMO[0]=1 after 15 WAIT cycles, REQ[0] falls, DONE[0] pulses, channel returns to IDLE.
- HOLD_CYC=0 with START[1] -> OWN[1] high for exactly 1 cycle. START[1] during BUSY has no effect.
- Assert RST_N=0 while a channel is in HOLD -> REQ, OWN, BUSY go 0 immediately. Release reset -> START works normally.
